// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   tx_state_t   - serialiser FSM states
//   DATA_*       - io_config_dataType encodings
//   STOP_*       - io_config_stopType encodings
//   PAR_*        - io_config_parityType encodings
//   data_bits()  - number of data bits sent for a given dataType
//   parity_bit() - parity bit value for a word under a given format
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_t;

  localparam logic [1:0] DATA_7      = 2'd0;
  localparam logic [1:0] DATA_8      = 2'd1;
  localparam logic [1:0] DATA_9      = 2'd2;
  localparam logic [1:0] DATA_8_RSVD = 2'd3;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;

  // The reserved dataType encoding behaves as plain 8-bit data.
  function automatic logic [3:0] data_bits(input logic [1:0] data_type);
    logic [3:0] n;
    case (data_type)
      DATA_7:      n = 4'd7;
      DATA_9:      n = 4'd9;
      DATA_8_RSVD: n = 4'd8;
      default:     n = 4'd8;
    endcase
    return n;
  endfunction

  // Only the bits actually transmitted contribute to the parity.
  function automatic logic parity_bit(input logic [1:0] parity_type,
                                      input logic [1:0] data_type,
                                      input logic [8:0] word);
    logic [8:0] mask;
    logic       even;
    logic       p;
    case (data_type)
      DATA_7:  mask = 9'h07F;
      DATA_9:  mask = 9'h1FF;
      default: mask = 9'h0FF;
    endcase
    even = ^(word & mask);
    case (parity_type)
      PAR_EVEN: p = even;
      PAR_ODD:  p = ~even;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock FIFO holding words waiting for the serialiser.
// DEPTH must be a power of two so the pointers wrap naturally.
//   clk, reset  - clock, synchronous active-high reset
//   push        - write push_data (ignored when full)
//   push_data   - word to store
//   pop         - discard the head word (ignored when empty)
//   pop_data    - head word, valid whenever count != 0
//   full        - no free entries
//   count       - registered occupancy, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered UART transmitter: a DEPTH-entry FIFO feeding a serialiser that
// supports 7/8/9 data bits, none/even/odd/mark parity, 1 or 2 stop bits and
// line-break generation.
// Optional build macro: UART_TX_CTS_EN adds io_cts_n (active-low clear to
// send, double-flop synchronised); frames only start while it is low.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   io_config_*            - frame format and bit period, latched per frame
//   io_data_valid/bits     - producer word (unused upper bits ignored)
//   io_data_ready          - FIFO can accept a word
//   io_break               - level request for a line break (sampled in IDLE)
//   io_cts_n               - clear to send, only with UART_TX_CTS_EN
//   io_tx                  - registered serial line, idle high
//   io_busy                - frame/break in progress or FIFO non-empty
//   io_count               - FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DIV_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 io_config_dataType,
  input  logic                       io_config_stopType,
  input  logic [1:0]                 io_config_parityType,
  input  logic [DIV_WIDTH-1:0]       io_config_clockDivider,
  input  logic                       io_data_valid,
  input  logic [8:0]                 io_data_bits,
  output logic                       io_data_ready,
  input  logic                       io_break,
`ifdef UART_TX_CTS_EN
  input  logic                       io_cts_n,
`endif
  output logic                       io_tx,
  output logic                       io_busy,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  tx_state_t            state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] baud_next;
  logic [1:0]           data_type_q;
  logic [1:0]           parity_type_q;
  logic                 stop_two_q;
  logic [8:0]           word_q;
  logic [8:0]           shift_q;
  logic [3:0]           bit_idx;
  logic                 stop_idx;

  logic                 full;
  logic [8:0]           fifo_data;
  logic                 push;
  logic                 pop;
  logic                 cts_ok;
  logic                 bit_end;
  logic                 stop_last;
  logic                 stop_done;
  logic                 can_start;
  logic                 start_frame;

  uart_sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (io_data_bits),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .count     (io_count)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Two-flop synchroniser for the asynchronous clear-to-send pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], io_cts_n};
    end
  end

  assign cts_ok = !cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign io_data_ready = !full && !reset;
  assign push          = io_data_valid && io_data_ready;
  assign io_busy       = (state != ST_IDLE) || (io_count != '0);

  assign bit_end   = (baud_cnt == div_q);
  assign baud_next = bit_end ? '0 : baud_cnt + 1'b1;
  assign stop_last = (stop_two_q == STOP_1) || stop_idx;
  assign stop_done = (state == ST_STOP) && bit_end && stop_last;

  // A queued word may start from IDLE or directly out of the final stop bit,
  // so consecutive frames run back to back; a break request holds it off.
  assign can_start   = (io_count != '0) && !io_break && cts_ok;
  assign start_frame = can_start && ((state == ST_IDLE) || stop_done);
  assign pop         = start_frame;

  // Serialiser FSM with registered line output and baud counter. Every
  // transition also sets io_tx for the bit that begins on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      io_tx         <= 1'b1;
      baud_cnt      <= '0;
      div_q         <= '0;
      data_type_q   <= DATA_8;
      parity_type_q <= PAR_NONE;
      stop_two_q    <= STOP_1;
      word_q        <= '0;
      shift_q       <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
    end else if (start_frame) begin
      state         <= ST_START;
      io_tx         <= 1'b0;
      baud_cnt      <= '0;
      div_q         <= io_config_clockDivider;
      data_type_q   <= io_config_dataType;
      parity_type_q <= io_config_parityType;
      stop_two_q    <= io_config_stopType;
      word_q        <= fifo_data;
      shift_q       <= fifo_data;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (io_break) begin
            state    <= ST_BREAK;
            io_tx    <= 1'b0;
            baud_cnt <= '0;
            div_q    <= io_config_clockDivider;
          end
        end
        ST_START: begin
          baud_cnt <= baud_next;
          if (bit_end) begin
            state   <= ST_DATA;
            io_tx   <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          baud_cnt <= baud_next;
          if (bit_end) begin
            if (bit_idx == data_bits(data_type_q) - 4'd1) begin
              if (parity_type_q != PAR_NONE) begin
                state <= ST_PARITY;
                io_tx <= parity_bit(parity_type_q, data_type_q, word_q);
              end else begin
                state    <= ST_STOP;
                io_tx    <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              io_tx   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          baud_cnt <= baud_next;
          if (bit_end) begin
            state    <= ST_STOP;
            io_tx    <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          baud_cnt <= baud_next;
          if (bit_end) begin
            if (stop_last) begin
              state <= ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          // Releasing the break always yields one full mark bit before
          // anything else can start.
          if (!io_break) begin
            state      <= ST_STOP;
            io_tx      <= 1'b1;
            stop_two_q <= STOP_1;
            stop_idx   <= 1'b0;
            baud_cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          io_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered: a format table with hand-derived
// bit patterns, a frame scoreboard, and hand-written sequences for
// back-to-back/full FIFO, mid-frame config change, break and reset.
module tb_uart_tx_buffered;

  localparam int DEPTH     = 8;
  localparam int DIV_WIDTH = 20;
  localparam int CW        = $clog2(DEPTH+1);

  logic                 clk;
  logic                 reset;
  logic [1:0]           io_config_dataType;
  logic                 io_config_stopType;
  logic [1:0]           io_config_parityType;
  logic [DIV_WIDTH-1:0] io_config_clockDivider;
  logic                 io_data_valid;
  logic [8:0]           io_data_bits;
  logic                 io_data_ready;
  logic                 io_break;
  logic                 io_tx;
  logic                 io_busy;
  logic [CW-1:0]        io_count;

  uart_tx_buffered #(
    .DEPTH     (DEPTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .io_config_dataType     (io_config_dataType),
    .io_config_stopType     (io_config_stopType),
    .io_config_parityType   (io_config_parityType),
    .io_config_clockDivider (io_config_clockDivider),
    .io_data_valid          (io_data_valid),
    .io_data_bits           (io_data_bits),
    .io_data_ready          (io_data_ready),
    .io_break               (io_break),
`ifdef UART_TX_CTS_EN
    .io_cts_n               (1'b0),
`endif
    .io_tx                  (io_tx),
    .io_busy                (io_busy),
    .io_count               (io_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit i of 'bits' is the line level during bit period i (bit 0 = start).
  typedef struct {
    logic [12:0] bits;
    int          len;
    int          div;
  } frame_t;

  typedef struct {
    logic [1:0]  dt;
    logic        st;
    logic [1:0]  pt;
    int          div;
    logic [8:0]  word;
    logic [12:0] exp_bits;
    int          exp_len;
  } vec_t;

  frame_t sb[$];
  vec_t   vecs[8];
  int     n_compared = 0;
  int     n_failed   = 0;
  int     saw_full   = 0;
  int     gap;
  int     gap_b;
  int     lows;

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_compared++;
    n_failed++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference frame built straight from the format description.
  function automatic frame_t frame_of(input logic [8:0] w, input logic [1:0] dt,
                                      input logic st, input logic [1:0] pt,
                                      input int div);
    frame_t f;
    int     n;
    int     k;
    logic   par;
    n      = (dt == 2'd0) ? 7 : ((dt == 2'd2) ? 9 : 8);
    f.bits = '0;
    f.div  = div;
    k      = 1;
    par    = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[k] = w[i];
      par       = par ^ w[i];
      k++;
    end
    if (pt != 2'd0) begin
      f.bits[k] = (pt == 2'd1) ? par : ((pt == 2'd2) ? ~par : 1'b1);
      k++;
    end
    for (int s = 0; s < (st ? 2 : 1); s++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.len = k;
    return f;
  endfunction

  // Called at a negedge; returns one negedge after the word was accepted.
  task automatic push_one(input logic [8:0] w);
    int guard;
    guard         = 0;
    io_data_valid = 1'b1;
    io_data_bits  = w;
    while (!io_data_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!io_data_ready) reportTimeout("push_ready");
    @(negedge clk);
    io_data_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    frame_t f;
    io_config_dataType     = v.dt;
    io_config_stopType     = v.st;
    io_config_parityType   = v.pt;
    io_config_clockDivider = DIV_WIDTH'(v.div);
    f.bits = v.exp_bits;
    f.len  = v.exp_len;
    f.div  = v.div;
    sb.push_back(f);
    push_one(v.word);
  endtask

  // Waits (bounded) for a start bit, pops the expected frame and checks the
  // line every cycle; returns at the negedge right after the last stop bit.
  task automatic checkOutput(input string tag, output int idle_cycles);
    frame_t f;
    idle_cycles = 0;
    while (io_tx === 1'b1 && idle_cycles < 5000) begin
      @(negedge clk);
      idle_cycles++;
    end
    if (io_tx !== 1'b0) begin
      reportTimeout({tag, "_start"});
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      reportTimeout({tag, "_scoreboard_empty"});
      return;
    end
    f = sb.pop_front();
    for (int b = 0; b < f.len; b++) begin
      for (int c = 0; c <= f.div; c++) begin
        checkValue($sformatf("%s_bit%0d", tag, b), {31'b0, io_tx}, {31'b0, f.bits[b]});
        if (b == f.len - 1 && c == f.div) checkValue({tag, "_busy_last"}, {31'b0, io_busy}, 1);
        @(negedge clk);
      end
    end
  endtask

  // Streams n random words, holding each while ready is low.
  task automatic produce(input int n);
    int         i;
    int         guard;
    logic [8:0] w;
    i             = 0;
    guard         = 0;
    w             = 9'($urandom_range(0, 255));
    io_data_valid = 1'b1;
    io_data_bits  = w;
    while (i < n && guard < 2000) begin
      checkValue("b2b_ready_vs_count", {31'b0, io_data_ready},
                 (io_count == CW'(DEPTH)) ? 32'd0 : 32'd1);
      if (io_count == CW'(DEPTH)) saw_full = 1;
      if (io_data_ready) begin
        sb.push_back(frame_of(w, io_config_dataType, io_config_stopType,
                              io_config_parityType, int'(io_config_clockDivider)));
        i++;
        w = 9'($urandom_range(0, 255));
      end
      @(negedge clk);
      guard++;
      if (i < n) io_data_bits = w;
      else io_data_valid = 1'b0;
    end
    if (i < n) reportTimeout("b2b_produce");
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Expected bit patterns derived by hand; bit i = line level in period i.
    vecs[0] = '{dt:2'd1, st:1'b1, pt:2'd2, div:7, word:9'h005, exp_bits:13'h0E0A, exp_len:12};
    vecs[1] = '{dt:2'd0, st:1'b0, pt:2'd0, div:2, word:9'h07F, exp_bits:13'h01FE, exp_len:9};
    vecs[2] = '{dt:2'd2, st:1'b0, pt:2'd1, div:2, word:9'h1FF, exp_bits:13'h0FFE, exp_len:12};
    vecs[3] = '{dt:2'd1, st:1'b0, pt:2'd3, div:2, word:9'h000, exp_bits:13'h0600, exp_len:11};
    vecs[4] = '{dt:2'd1, st:1'b0, pt:2'd0, div:2, word:9'h0A5, exp_bits:13'h034A, exp_len:10};
    vecs[5] = '{dt:2'd2, st:1'b1, pt:2'd2, div:2, word:9'h100, exp_bits:13'h1A00, exp_len:13};
    vecs[6] = '{dt:2'd3, st:1'b0, pt:2'd1, div:2, word:9'h1C3, exp_bits:13'h0586, exp_len:11};
    vecs[7] = '{dt:2'd0, st:1'b1, pt:2'd1, div:2, word:9'h181, exp_bits:13'h0702, exp_len:11};

    reset                  = 1'b1;
    io_data_valid          = 1'b0;
    io_data_bits           = '0;
    io_break               = 1'b0;
    io_config_dataType     = 2'd1;
    io_config_stopType     = 1'b0;
    io_config_parityType   = 2'd0;
    io_config_clockDivider = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkValue("rst_tx", {31'b0, io_tx}, 1);
    checkValue("rst_busy", {31'b0, io_busy}, 0);
    checkValue("rst_count", {28'b0, io_count}, 0);
    checkValue("rst_ready", {31'b0, io_data_ready}, 0);
    reset = 1'b0;
    #1;
    checkValue("rst_release_ready", {31'b0, io_data_ready}, 1);
    @(negedge clk);

    // Format table: latency, exact bits, frame end
    $display("[TB] format table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), gap);
      checkValue($sformatf("vec%0d_latency", i), gap, 1);
      checkValue($sformatf("vec%0d_end_tx", i), {31'b0, io_tx}, 1);
      checkValue($sformatf("vec%0d_end_busy", i), {31'b0, io_busy}, 0);
      @(negedge clk);
    end

    // Back-to-back stream through a full FIFO
    $display("[TB] back-to-back and full");
    io_config_dataType     = 2'd1;
    io_config_stopType     = 1'b0;
    io_config_parityType   = 2'd0;
    io_config_clockDivider = '0;
    fork
      produce(DEPTH + 2);
      begin
        for (int k = 0; k < DEPTH + 2; k++) begin
          checkOutput($sformatf("b2b%0d", k), gap_b);
          if (k == 0) checkValue("b2b_first_gap", gap_b, 2);
          else checkValue($sformatf("b2b%0d_gap", k), gap_b, 0);
        end
      end
    join
    checkValue("b2b_saw_full", saw_full, 1);
    checkValue("b2b_count_end", {28'b0, io_count}, 0);
    checkValue("b2b_busy_end", {31'b0, io_busy}, 0);
    @(negedge clk);

    // Parity switched off while the first frame is in DATA
    $display("[TB] mid-frame config change");
    io_config_dataType     = 2'd1;
    io_config_stopType     = 1'b0;
    io_config_parityType   = 2'd1;
    io_config_clockDivider = DIV_WIDTH'(3);
    fork
      begin
        sb.push_back(frame_of(9'h001, 2'd1, 1'b0, 2'd1, 3));
        push_one(9'h001);
        repeat (15) @(negedge clk);
        io_config_parityType = 2'd0;
        sb.push_back(frame_of(9'h080, 2'd1, 1'b0, 2'd0, 3));
        push_one(9'h080);
      end
      begin
        checkOutput("cfgA", gap_b);
        checkValue("cfgA_gap", gap_b, 2);
        checkOutput("cfgB", gap_b);
        checkValue("cfgB_gap", gap_b, 0);
      end
    join
    checkValue("cfg_end_busy", {31'b0, io_busy}, 0);
    @(negedge clk);

    // Break with a word queued behind it
    $display("[TB] break");
    io_config_parityType = 2'd0;
    io_break             = 1'b1;
    sb.push_back(frame_of(9'h0C3, 2'd1, 1'b0, 2'd0, 3));
    lows = 0;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (j == 1) begin
        io_data_valid = 1'b1;
        io_data_bits  = 9'h0C3;
      end
      if (j == 2) io_data_valid = 1'b0;
      if (io_tx == 1'b0) lows++;
    end
    checkValue("brk_low_cycles", lows, 50);
    checkValue("brk_count_held", {28'b0, io_count}, 1);
    checkValue("brk_busy", {31'b0, io_busy}, 1);
    io_break = 1'b0;
    @(negedge clk);
    checkOutput("brk_frame", gap);
    checkValue("brk_stop_gap", gap, 4);
    checkValue("brk_end_busy", {31'b0, io_busy}, 0);
    @(negedge clk);

    // Reset during DATA bit 3 with a second word queued
    $display("[TB] reset mid-frame");
    push_one(9'h000);
    push_one(9'h055);
    repeat (17) @(negedge clk);
    checkValue("mid_pre_reset_tx", {31'b0, io_tx}, 0);
    reset         = 1'b1;
    io_data_valid = 1'b1;
    io_data_bits  = 9'h1FF;
    #1;
    checkValue("mid_rst_ready", {31'b0, io_data_ready}, 0);
    @(negedge clk);
    checkValue("mid_rst_tx", {31'b0, io_tx}, 1);
    checkValue("mid_rst_count", {28'b0, io_count}, 0);
    checkValue("mid_rst_busy", {31'b0, io_busy}, 0);
    checkValue("mid_rst_ready2", {31'b0, io_data_ready}, 0);
    reset         = 1'b0;
    io_data_valid = 1'b0;
    #1;
    checkValue("mid_post_ready", {31'b0, io_data_ready}, 1);
    lows = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (io_tx !== 1'b1 || io_busy !== 1'b0) lows++;
    end
    checkValue("mid_no_residual", lows, 0);
    checkValue("mid_count_after", {28'b0, io_count}, 0);

    checkValue("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered, parametrised UART transmitter: next generation of the single-word UartTx. Adds:
- a DEPTH-entry TX FIFO in front of the serialiser;
- a configurable divider width;
- mark parity and line-break generation;
- status outputs.
Sits between a bus-side register block (valid/ready producer) and the chip pad io_tx.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
DIV_WIDTH, 20, width of io_config_clockDivider

Ports:
clk  in  1  clock
reset  in  1  reset
io_config_dataType  in  2  0=7 bits, 1=8 bits, 2=9 bits, 3=8 bits (reserved)
io_config_stopType  in  1  0=1 stop bit, 1=2 stop bits
io_config_parityType  in  2  0=none, 1=even, 2=odd, 3=mark (always 1)
io_config_clockDivider  in  DIV_WIDTH  bit period minus 1, in clk cycles
io_data_valid  in  1  producer word valid
io_data_bits  in  9  word; unused upper bits ignored
io_data_ready  out  1  FIFO can accept
io_break  in  1  level request to drive a line break
io_tx  out  1  serial line, registered, idle high
io_busy  out  1  frame or break in progress, or FIFO non-empty
io_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
Reset and clocking:
- Single clock clk. reset is synchronous and active-high.
- Reset values: io_tx=1, io_busy=0, io_count=0, FIFO empty, FSM in IDLE, io_data_ready=0 while reset is high.
- Reset mid-frame aborts immediately; io_tx is 1 on the first cycle after reset.

FIFO handshake:
- io_data_ready = !full && !reset.
- Push on valid&&ready. Stable-while-valid is not required.
- Simultaneous push and pop is allowed at any non-full occupancy.
- When full, ready=0 and the word is held by the producer.
- No fall-through.

Bit timing:
- Each bit lasts clockDivider+1 cycles, counted by a DIV_WIDTH baud counter.
- clockDivider=0 gives one cycle per bit.

Configuration sampling:
- All io_config_* fields are latched when a frame leaves IDLE.
- Changes mid-frame take effect on the next frame only.

FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - io_break=1 -> BREAK (break has priority over pending data).
  - Otherwise, if count>0: pop, latch word and config -> START.
- START: io_tx=0 for one bit -> DATA.
- DATA:
  - Send N bits (N=7/8/9 from dataType), LSB first.
  - -> PARITY if parityType!=0, else -> STOP.
- PARITY:
  - even: XOR of the N data bits.
  - odd: inverse of even.
  - mark: 1.
  - One bit, then -> STOP.
- STOP: io_tx=1 for 1 or 2 bits -> IDLE. A pending word starts on the next cycle, giving back-to-back frames with no idle gap.
- BREAK:
  - io_tx=0 while io_break=1.
  - On deassert -> STOP with 1 stop bit forced, so at least one bit period of mark follows the break.
  - io_break is ignored outside IDLE; the current frame completes first.

Latency:
- Word accepted in cycle n with FIFO empty and FSM idle: pop in cycle n+1, io_tx falls at start of cycle n+2.

Status:
- io_busy = (state!=IDLE) || (count!=0).
- io_count is registered and updates on the cycle after push/pop.

Frame length:
- 1 + N + P + S bit periods, where P is 0/1 and S is 1/2.

Optional Feature:
UART_TX_CTS_EN:
- When defined, adds input port io_cts_n (1 bit, active-low clear-to-send, synchronised internally by a 2-flop synchroniser).
- IDLE leaves to START only when the synchronised cts_n=0.
- A frame already started always completes, regardless of cts.
- Break is unaffected by cts.
- When not defined, the port is absent and frames start whenever the FIFO is non-empty.

Decomposition:
- Package uart_pkg:
  - FSM state enum;
  - dataType, stopType and parityType encodings as localparams;
  - function mapping dataType to bit count (3 -> 8);
  - function computing the parity bit.
- Sub-module uart_sync_fifo(WIDTH=9, DEPTH) holds storage, pointers and count; the serialiser FSM and baud counter stay in uart_tx_buffered.

Test Plan:
1. Basic 8O2: dataType=1, stopType=1, parityType=2, divider=7, push 8'h05 -> io_tx low at cycle n+2 for 8 cycles, then data 1,0,1,0,0,0,0,0, parity 1, two stop bits; frame = 96 cycles; io_busy falls after the last stop bit.
2. Back-to-back and full: divider=0, push DEPTH+2 words continuously -> io_data_ready low once io_count=8, all words transmitted in order, no idle gap between frames, io_count returns to 0.
3. Format sweep: 7N1 with 0x7F, 9E1 with 0x1FF (parity 1), 8M1 with 0x00 (parity 1) -> exact bit sequences; frame lengths 9, 12 and 11 bit periods.
4. Mid-frame config change: change parityType from 1 to 0 during DATA -> current frame keeps parity; the next frame has none.
5. Break: raise io_break for 50 cycles while in IDLE, with a word queued -> io_tx low 50 cycles, then one stop bit high, then the queued frame starts.
6. Reset mid-frame at DATA bit 3 -> next cycle io_tx=1, io_count=0, io_data_ready=0 during reset and 1 after; no residual frame follows.
